ss_scan_driver: RTL



---
 rtl/ss_scan_driver.sv | 122 ++++++++++++
 1 files changed

// File: rtl/ss_scan_driver.sv
// Four-digit multiplexed seven-segment scan driver with per-frame input snapshot.
// Optional SS_DIMMING_EN adds a 4-bit Brightness input that shortens each digit's on-time.
module ss_scan_driver #(
  parameter int CLK_HZ   = 100_000_000,
  parameter int FRAME_HZ = 250
) (
  input  logic       CLK100MHZ,
  input  logic       Reset,
  input  logic [3:0] BCD3,
  input  logic [3:0] BCD2,
  input  logic [3:0] BCD1,
  input  logic [3:0] BCD0,
  input  logic [3:0] DP,
  input  logic       LZBlank,
`ifdef SS_DIMMING_EN
  input  logic [3:0] Brightness,
`endif
  output logic [3:0] SegmentDrivers,
  output logic [7:0] SevenSegment,
  output logic       FrameStart
);

  localparam int SLOT = CLK_HZ / (4 * FRAME_HZ);
  localparam int CW   = (SLOT > 2) ? $clog2(SLOT) : 1;
  localparam int PW   = CW + 5;
  localparam logic [CW-1:0] SLOT_LAST = CW'(SLOT - 1);

  logic [CW-1:0]   cnt_q, cnt_d;
  logic [1:0]      idx_q, idx_d;
  logic            first_q;
  logic [3:0][3:0] bcd_q;
  logic [3:0]      dp_q;
  logic            lzb_q;
  logic [3:0]      an_q, an_d;
  logic [7:0]      seg_q, seg_d;
  logic            fs_q;
  logic            frame_start, slot_wrap, digit_on, dim_ok;
`ifdef SS_DIMMING_EN
  logic [3:0]      bri_q;
`endif

  function automatic logic [6:0] glyph(input logic [3:0] v);
    case (v)
      4'h0: glyph = 7'b100_0000;
      4'h1: glyph = 7'b111_1001;
      4'h2: glyph = 7'b010_0100;
      4'h3: glyph = 7'b011_0000;
      4'h4: glyph = 7'b001_1001;
      4'h5: glyph = 7'b001_0010;
      4'h6: glyph = 7'b000_0010;
      4'h7: glyph = 7'b111_1000;
      4'h8: glyph = 7'b000_0000;
      4'h9: glyph = 7'b001_0000;
      4'hA: glyph = 7'b000_1000;
      4'hB: glyph = 7'b000_0011;
      4'hC: glyph = 7'b100_0110;
      4'hD: glyph = 7'b010_0001;
      4'hE: glyph = 7'b000_0110;
      default: glyph = 7'b000_1110;
    endcase
  endfunction

  // first_q makes the first edge after reset a frame start without disturbing cnt/idx.
  always_comb begin
    slot_wrap   = (cnt_q == SLOT_LAST);
    frame_start = first_q | (slot_wrap && idx_q == 2'd3);
    cnt_d       = (slot_wrap || first_q) ? '0 : cnt_q + 1'b1;
    idx_d       = first_q ? 2'd0 : (slot_wrap ? idx_q + 2'd1 : idx_q);
  end

  always_comb begin
    dim_ok = 1'b1;
`ifdef SS_DIMMING_EN
    dim_ok = ((PW'(cnt_q)) << 4) < (PW'({1'b0, bri_q} + 5'd1) * PW'(SLOT));
`endif
    digit_on = (cnt_q != '0) && dim_ok &&
               !(idx_q == 2'd3 && lzb_q && bcd_q[3] == 4'h0);
    an_d  = 4'hF;
    seg_d = 8'hFF;
    if (digit_on) begin
      an_d  = ~(4'b0001 << idx_q);
      seg_d = {~dp_q[idx_q], glyph(bcd_q[idx_q])};
    end
  end

  always_ff @(posedge CLK100MHZ) begin
    if (Reset) begin
      cnt_q   <= '0;
      idx_q   <= 2'd0;
      first_q <= 1'b1;
      bcd_q   <= '0;
      dp_q    <= 4'h0;
      lzb_q   <= 1'b0;
      an_q    <= 4'hF;
      seg_q   <= 8'hFF;
      fs_q    <= 1'b0;
`ifdef SS_DIMMING_EN
      bri_q   <= 4'h0;
`endif
    end else begin
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      first_q <= 1'b0;
      an_q    <= an_d;
      seg_q   <= seg_d;
      fs_q    <= frame_start;
      if (frame_start) begin
        bcd_q <= {BCD3, BCD2, BCD1, BCD0};
        dp_q  <= DP;
        lzb_q <= LZBlank;
`ifdef SS_DIMMING_EN
        bri_q <= Brightness;
`endif
      end
    end
  end

  assign SegmentDrivers = an_q;
  assign SevenSegment   = seg_q;
  assign FrameStart     = fs_q;

endmodule
